drive_pwr_seq: RTL and testbench
================================

Name: drive_pwr_seq

Overview:
- Per-drive power sequencer in the baseboard CPLD.
- Enables each drive's hot-swap/eFuse rail, qualifies the returned power-good, and produces the DRVn_PWROK level that the PCIe reset controller consumes to time PERST# release.
- On power-down it drops PWROK first, so PERST# asserts while the rail is still up, then removes power.
- Staggers power-on across drives to limit inrush.

Parameters:
- NUM_DRV, 24, number of drive slots.
- PG_TIMEOUT_CYC, 32'd2500000, max SYSCLK cycles from PWR_EN to stable power-good before fault.
- PG_STABLE_CYC, 32'd25000, consecutive cycles power-good must be high before PWROK.
- STAGGER_CYC, 32'd1250000, minimum cycles between successive power-on grants.
- OFF_DLY_CYC, 32'd250000, cycles PWROK is low before PWR_EN drops.
- MIN_OFF_CYC, 32'd2500000, minimum rail-off time before re-enable.

Ports:
- SYSCLK, in, 1, system clock.
- RESET_N, in, 1, synchronous active-low reset.
- DRV_PRSNT_N, in, NUM_DRV, drive present, active low; pre-synchronised.
- DRV_PWR_REQ, in, NUM_DRV, BMC/host request to power slot i.
- DRV_PWRGD, in, NUM_DRV, eFuse power-good; pre-synchronised.
- DRV_FAULT_CLR, in, NUM_DRV, single-cycle pulse that clears a latched fault.
- DRV_PWR_EN, out, NUM_DRV, rail enable.
- DRV_PWROK, out, NUM_DRV, qualified power-ok to the PCIe reset controller.
- DRV_FAULT, out, NUM_DRV, latched fault status.

Behaviour:
- Reset is synchronous on the SYSCLK edge when RESET_N=0:
  - All per-slot FSMs go to OFF.
  - All counters are cleared, the stagger timer is 0.
  - All outputs are 0.
- All outputs are registered and update on the same edge as the state change.
- Reset applied mid-operation drops PWR_EN immediately, with no OFF_DLY.
- Per-slot FSM, with a 32-bit counter CNT[i]:
  - OFF: EN=0, OK=0. If PRSNT_N[i]=0 and PWR_REQ[i]=1, go to WAIT_SLOT.
  - WAIT_SLOT: EN=0.
    - If PWR_REQ[i]=0 or PRSNT_N[i]=1, go to OFF.
    - If granted, go to RAMP with CNT=0.
  - RAMP: EN=1, OK=0.
    - CNT increments every cycle.
    - A stable counter counts consecutive PWRGD=1 cycles and resets on PWRGD=0.
    - Stable count reaching PG_STABLE_CYC: go to ON.
    - Otherwise CNT reaching PG_TIMEOUT_CYC: go to FAULT. Stable completion wins if both hit on the same cycle.
    - PWR_REQ=0 or removal: go to COOL.
  - ON: EN=1, OK=1.
    - PWRGD=0 for any single cycle: go to FAULT. This has priority over a request drop on the same cycle.
    - PRSNT_N=1: go to COOL (surprise removal, no delay).
    - PWR_REQ=0: go to PRE_OFF with CNT=0.
  - PRE_OFF: EN=1, OK=0.
    - CNT reaching OFF_DLY_CYC-1: go to COOL.
    - Removal: go to COOL immediately.
    - A PWR_REQ re-assert is ignored until OFF is reached.
  - COOL: EN=0, OK=0. After MIN_OFF_CYC cycles, go to OFF.
  - FAULT: EN=0, OK=0, FAULT=1.
    - FAULT_CLR[i] or PRSNT_N[i]=1: go to COOL, with FAULT cleared on the same edge.
    - PWR_REQ is ignored while in FAULT.
- Stagger arbiter:
  - A single global down-counter STG.
  - When STG=0, the lowest-index slot in WAIT_SLOT is granted and STG loads STAGGER_CYC-1.
  - Otherwise STG decrements, saturating at 0.
  - At most one grant per cycle; no grant is issued while STG≠0.
  - A granted slot that has since left WAIT_SLOT still consumes the interval.
- Counters saturate and never wrap.
- Slots are independent apart from the shared arbiter.

Optional Feature:
- Macro: DRV_PWR_STAGGER_EN.
- Defined: the stagger arbiter operates as specified above.
- Undefined: the arbiter and STG are removed. Every slot in WAIT_SLOT is granted on the cycle it enters, so multiple slots may enter RAMP on the same edge. STAGGER_CYC is unused.

Test Plan:
(Bench parameters: NUM_DRV=4, PG_TIMEOUT=100, PG_STABLE=4, STAGGER=20, OFF_DLY=10, MIN_OFF=8; STAGGER_EN defined.)
- Nominal power-up:
  - Stimulus: slot0 present, REQ0 rises at cycle t, PWRGD0 high from EN0 rise+3.
  - Response: WAIT_SLOT at t+1, EN0=1 at t+2, OK0=1 exactly 4 cycles after PWRGD0 first seen high, FAULT0=0.
- Stagger:
  - Stimulus: REQ0..3 assert on the same cycle.
  - Response: EN0, EN1, EN2, EN3 rise at 20-cycle spacing, in index order.
- Power-good timeout:
  - Stimulus: PWRGD1 held 0 after EN1.
  - Response: EN1 drops and FAULT1=1 at CNT=100. REQ1 toggling has no effect. A FAULT_CLR1 pulse leads to OFF after 8 COOL cycles, then re-sequencing.
- Orderly off:
  - Stimulus: slot ON, REQ2 deasserted.
  - Response: OK2=0 the next edge, EN2 stays 1 for 10 cycles then drops. A REQ2 re-assert during COOL gives EN2 no sooner than 8 cycles after the drop, plus arbitration.
- Brown-out and surprise removal:
  - Stimulus: 1-cycle PWRGD3=0 glitch while ON.
  - Response: FAULT3=1, EN3=0 and OK3=0 on the next edge.
  - Stimulus: PRSNT_N=1 while in PRE_OFF.
  - Response: EN drops on the next edge.
- Reset mid-RAMP:
  - Stimulus: RESET_N=0 for 1 cycle while slot0 is in RAMP.
  - Response: all outputs 0 on the next edge, STG=0. After release, slot0 re-arbitrates from OFF.

Source files
------------

// File: rtl/drive_pwr_seq.sv
// rtl/drive_pwr_seq.sv - per-drive rail enable / PWROK sequencer with power-on stagger
// Define DRV_PWR_STAGGER_EN to serialise power-on grants through a shared stagger timer.
module drive_pwr_seq #(
  parameter int unsigned NUM_DRV        = 24,
  parameter logic [31:0] PG_TIMEOUT_CYC = 32'd2500000,
  parameter logic [31:0] PG_STABLE_CYC  = 32'd25000,
  parameter logic [31:0] STAGGER_CYC    = 32'd1250000,
  parameter logic [31:0] OFF_DLY_CYC    = 32'd250000,
  parameter logic [31:0] MIN_OFF_CYC    = 32'd2500000
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic [NUM_DRV-1:0] DRV_PRSNT_N,
  input  logic [NUM_DRV-1:0] DRV_PWR_REQ,
  input  logic [NUM_DRV-1:0] DRV_PWRGD,
  input  logic [NUM_DRV-1:0] DRV_FAULT_CLR,
  output logic [NUM_DRV-1:0] DRV_PWR_EN,
  output logic [NUM_DRV-1:0] DRV_PWROK,
  output logic [NUM_DRV-1:0] DRV_FAULT
);

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_WAIT_SLOT = 3'd1;
  localparam logic [2:0] ST_RAMP      = 3'd2;
  localparam logic [2:0] ST_ON        = 3'd3;
  localparam logic [2:0] ST_PRE_OFF   = 3'd4;
  localparam logic [2:0] ST_COOL      = 3'd5;
  localparam logic [2:0] ST_FAULT     = 3'd6;

  logic [NUM_DRV-1:0] waiting;
  logic [NUM_DRV-1:0] grant;

`ifdef DRV_PWR_STAGGER_EN
  logic [31:0] stg;

  // Lowest-index waiting slot wins; a grant is only issued once the stagger timer has expired.
  always_comb begin
    grant = '0;
    if (stg == 32'd0) begin
      for (int i = NUM_DRV - 1; i >= 0; i--) begin
        if (waiting[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      stg <= '0;
    end else if (|grant) begin
      stg <= (STAGGER_CYC != 32'd0) ? STAGGER_CYC - 32'd1 : 32'd0;
    end else if (stg != 32'd0) begin
      stg <= stg - 32'd1;
    end
  end
`else
  logic unused_stagger_cyc;
  assign unused_stagger_cyc = ^STAGGER_CYC;
  assign grant = waiting;
`endif

  for (genvar i = 0; i < NUM_DRV; i++) begin : g_slot
    logic [2:0]  state;
    logic [2:0]  nxt;
    logic [31:0] cnt;
    logic [31:0] stab;
    logic        present;
    logic        req;
    logic        pg;
    logic        en_q;
    logic        ok_q;
    logic        flt_q;

    assign present    = ~DRV_PRSNT_N[i];
    assign req        = DRV_PWR_REQ[i];
    assign pg         = DRV_PWRGD[i];
    assign waiting[i] = (state == ST_WAIT_SLOT);

    always_comb begin
      nxt = state;
      case (state)
        ST_OFF: begin
          if (present && req) nxt = ST_WAIT_SLOT;
        end
        ST_WAIT_SLOT: begin
          if (!req || !present) nxt = ST_OFF;
          else if (grant[i])    nxt = ST_RAMP;
        end
        ST_RAMP: begin
          if (pg && (stab >= PG_STABLE_CYC - 32'd1)) nxt = ST_ON;
          else if (cnt >= PG_TIMEOUT_CYC - 32'd1)    nxt = ST_FAULT;
          else if (!req || !present)                 nxt = ST_COOL;
        end
        ST_ON: begin
          // A power-good dropout is a fault even if the host is asking to power down.
          if (!pg)          nxt = ST_FAULT;
          else if (!present) nxt = ST_COOL;
          else if (!req)     nxt = ST_PRE_OFF;
        end
        ST_PRE_OFF: begin
          if (!present || (cnt >= OFF_DLY_CYC - 32'd1)) nxt = ST_COOL;
        end
        ST_COOL: begin
          if (cnt >= MIN_OFF_CYC - 32'd1) nxt = ST_OFF;
        end
        ST_FAULT: begin
          if (DRV_FAULT_CLR[i] || !present) nxt = ST_COOL;
        end
        default: nxt = ST_OFF;
      endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge SYSCLK) begin
      if (!RESET_N) begin
        state <= ST_OFF;
        cnt   <= '0;
        stab  <= '0;
        en_q  <= 1'b0;
        ok_q  <= 1'b0;
        flt_q <= 1'b0;
      end else begin
        state <= nxt;
        en_q  <= (nxt == ST_RAMP) || (nxt == ST_ON) || (nxt == ST_PRE_OFF);
        ok_q  <= (nxt == ST_ON);
        flt_q <= (nxt == ST_FAULT);
        if (nxt != state)      cnt <= '0;
        else if (cnt != '1)    cnt <= cnt + 32'd1;
        if ((nxt != state) || !pg) stab <= '0;
        else if (stab != '1)       stab <= stab + 32'd1;
      end
    end

    assign DRV_PWR_EN[i] = en_q;
    assign DRV_PWROK[i]  = ok_q;
    assign DRV_FAULT[i]  = flt_q;
  end

endmodule

// File: tb/tb_drive_pwr_seq.sv
// tb/tb_drive_pwr_seq.sv - directed vector bench for drive_pwr_seq (4 slots, short timers)
// Stagger expectations follow DRV_PWR_STAGGER_EN when it is defined for the whole build.
module tb_drive_pwr_seq;

  localparam int NDRV = 4;
`ifdef DRV_PWR_STAGGER_EN
  localparam int GAP = 20;
`else
  localparam int GAP = 0;
`endif

  logic            SYSCLK = 1'b0;
  logic            RESET_N;
  logic [NDRV-1:0] DRV_PRSNT_N;
  logic [NDRV-1:0] DRV_PWR_REQ;
  logic [NDRV-1:0] DRV_PWRGD;
  logic [NDRV-1:0] DRV_FAULT_CLR;
  logic [NDRV-1:0] DRV_PWR_EN;
  logic [NDRV-1:0] DRV_PWROK;
  logic [NDRV-1:0] DRV_FAULT;

  int total = 0;
  int bad   = 0;

  drive_pwr_seq #(
    .NUM_DRV       (NDRV),
    .PG_TIMEOUT_CYC(32'd100),
    .PG_STABLE_CYC (32'd4),
    .STAGGER_CYC   (32'd20),
    .OFF_DLY_CYC   (32'd10),
    .MIN_OFF_CYC   (32'd8)
  ) dut (
    .SYSCLK       (SYSCLK),
    .RESET_N      (RESET_N),
    .DRV_PRSNT_N  (DRV_PRSNT_N),
    .DRV_PWR_REQ  (DRV_PWR_REQ),
    .DRV_PWRGD    (DRV_PWRGD),
    .DRV_FAULT_CLR(DRV_FAULT_CLR),
    .DRV_PWR_EN   (DRV_PWR_EN),
    .DRV_PWROK    (DRV_PWROK),
    .DRV_FAULT    (DRV_FAULT)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    string           name;
    logic [NDRV-1:0] req;
    logic [NDRV-1:0] pg;
    logic [NDRV-1:0] clr;
    int              cyc;
    logic [NDRV-1:0] en;
    logic [NDRV-1:0] ok;
    logic [NDRV-1:0] flt;
  } vec_t;

  vec_t tbl[$];

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  task automatic check(input string name, input logic [NDRV-1:0] en_e,
                       input logic [NDRV-1:0] ok_e, input logic [NDRV-1:0] flt_e);
    total++;
    if ({DRV_PWR_EN, DRV_PWROK, DRV_FAULT} !== {en_e, ok_e, flt_e}) begin
      bad++;
      $display("FAIL %s: en/ok/fault got %b/%b/%b want %b/%b/%b", name,
               DRV_PWR_EN, DRV_PWROK, DRV_FAULT, en_e, ok_e, flt_e);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET_N       = 1'b0;
    DRV_PRSNT_N   = '0;
    DRV_PWR_REQ   = '0;
    DRV_PWRGD     = '0;
    DRV_FAULT_CLR = '0;
    tick(1);
    RESET_N = 1'b1;
  endtask

  task automatic power_on(input int s);
    DRV_PWR_REQ[s] = 1'b1;
    tick(2);
    check_int($sformatf("pon%0d_en", s), int'(DRV_PWR_EN[s]), 1);
    DRV_PWRGD[s] = 1'b1;
    tick(4);
    check_int($sformatf("pon%0d_ok", s), int'(DRV_PWROK[s]), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rise[NDRV];

    // Slot 0: nominal power-up, orderly off with re-request in COOL, brown-out, fault clear.
    tbl.push_back('{"wait_slot",      4'b0001, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"en_rise",        4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{"ramp_pg_low",    4'b0001, 4'b0000, 4'b0000, 2, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{"pg_stabilising", 4'b0001, 4'b0001, 4'b0000, 3, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{"pwrok",          4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0000});
    tbl.push_back('{"on_hold",        4'b0001, 4'b0001, 4'b0000, 5, 4'b0001, 4'b0001, 4'b0000});
    tbl.push_back('{"pre_off_ok_low", 4'b0000, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{"pre_off_hold",   4'b0000, 4'b0001, 4'b0000, 9, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{"en_drop",        4'b0000, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"cool_req_back",  4'b0001, 4'b0001, 4'b0000, 7, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"cool_to_off",    4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"rewait",         4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"regrant",        4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{"reramp_ok",      4'b0001, 4'b0001, 4'b0000, 4, 4'b0001, 4'b0001, 4'b0000});
    tbl.push_back('{"brownout",       4'b0001, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001});
    tbl.push_back('{"fault_req_low",  4'b0000, 4'b0001, 4'b0000, 3, 4'b0000, 4'b0000, 4'b0001});
    tbl.push_back('{"fault_req_high", 4'b0001, 4'b0001, 4'b0000, 3, 4'b0000, 4'b0000, 4'b0001});
    tbl.push_back('{"fault_clr",      4'b0001, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"cool_after_clr", 4'b0001, 4'b0001, 4'b0000, 8, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"rewait2",        4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{"regrant2",       4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000});

    do_reset();
    check("reset_state", 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < tbl.size(); k++) begin
      DRV_PWR_REQ   = tbl[k].req;
      DRV_PWRGD     = tbl[k].pg;
      DRV_FAULT_CLR = tbl[k].clr;
      tick(tbl[k].cyc);
      check(tbl[k].name, tbl[k].en, tbl[k].ok, tbl[k].flt);
    end

    // All four slots request together: EN rises in index order at the stagger spacing.
    do_reset();
    for (int i = 0; i < NDRV; i++) rise[i] = -1;
    DRV_PWR_REQ = 4'b1111;
    for (int c = 1; c <= 80; c++) begin
      tick(1);
      for (int i = 0; i < NDRV; i++)
        if (rise[i] < 0 && DRV_PWR_EN[i]) rise[i] = c;
    end
    for (int i = 0; i < NDRV; i++)
      check_int($sformatf("stagger_rise%0d", i), rise[i], 2 + i * GAP);

    // Slot 1: power-good never arrives, fault latches, request ignored, clear re-sequences.
    do_reset();
    DRV_PWR_REQ = 4'b0010;
    tick(2);
    check("to_ramp", 4'b0010, 4'b0000, 4'b0000);
    n = 0;
    while (DRV_PWR_EN[1] && n < 200) begin
      tick(1);
      n++;
    end
    check_int("timeout_cycles", n, 100);
    check("timeout_fault", 4'b0000, 4'b0000, 4'b0010);
    DRV_PWR_REQ = 4'b0000;
    tick(3);
    check("to_req_low", 4'b0000, 4'b0000, 4'b0010);
    DRV_PWR_REQ = 4'b0010;
    tick(3);
    check("to_req_high", 4'b0000, 4'b0000, 4'b0010);
    DRV_FAULT_CLR = 4'b0010;
    tick(1);
    DRV_FAULT_CLR = 4'b0000;
    check("to_clr", 4'b0000, 4'b0000, 4'b0000);
    n = 0;
    while (!DRV_PWR_EN[1] && n < 50) begin
      tick(1);
      n++;
    end
    check_int("to_reseq_cycles", n, 10);
    check("to_reseq", 4'b0010, 4'b0000, 4'b0000);

    // Slot 2: orderly off interrupted by surprise removal in PRE_OFF.
    do_reset();
    power_on(2);
    DRV_PWR_REQ = 4'b0000;
    tick(1);
    check("rm_pre_off", 4'b0100, 4'b0000, 4'b0000);
    tick(3);
    check("rm_pre_off_hold", 4'b0100, 4'b0000, 4'b0000);
    DRV_PRSNT_N = 4'b0100;
    tick(1);
    check("rm_en_drop", 4'b0000, 4'b0000, 4'b0000);

    // Slot 3: single-cycle brown-out while ON latches a fault.
    do_reset();
    power_on(3);
    DRV_PWRGD = 4'b0000;
    tick(1);
    DRV_PWRGD = 4'b1000;
    check("bo_fault", 4'b0000, 4'b0000, 4'b1000);
    tick(2);
    check("bo_latched", 4'b0000, 4'b0000, 4'b1000);

    // Slot 0: reset in RAMP clears everything including the stagger timer.
    do_reset();
    DRV_PWR_REQ = 4'b0001;
    tick(2);
    check("rr_ramp", 4'b0001, 4'b0000, 4'b0000);
    tick(2);
    RESET_N = 1'b0;
    tick(1);
    check("rr_reset", 4'b0000, 4'b0000, 4'b0000);
    RESET_N = 1'b1;
    tick(1);
    check("rr_wait", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check("rr_regrant", 4'b0001, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
